// File: rtl/user_str_fetch_pkg.sv
// user_str_fetch_pkg: shared types and constants for the string fetcher and its OBI port.
// Latency: n/a (types, constants and a combinational byte-select helper only).
// Backpressure: n/a.
package user_str_fetch_pkg;

  localparam int unsigned ObiAddrWidth = 32;
  localparam int unsigned ObiDataWidth = 32;
  localparam int unsigned ObiIdWidth   = 1;

  localparam logic [7:0] StrNul      = 8'h00;
  localparam int unsigned StrLenWidth = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    EMIT,
    DONE
  } str_fetch_state_e;

  typedef struct packed {
    logic [ObiAddrWidth-1:0]   addr;
    logic                      we;
    logic [ObiDataWidth/8-1:0] be;
    logic [ObiDataWidth-1:0]   wdata;
    logic [ObiIdWidth-1:0]     aid;
    logic                      a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [ObiDataWidth-1:0] rdata;
    logic [ObiIdWidth-1:0]   rid;
    logic                    err;
    logic                    r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

  // Little-endian byte select: idx 0 is the lowest-addressed byte of the word.
  function automatic logic [7:0] str_word_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/user_str_fetch.sv
// user_str_fetch: OBI manager walking a NUL-terminated string in word ROM, streaming it one byte per handshake.
// Latency: start at cycle 0 -> req at cycle 1 -> first byte_valid_o at cycle 3 (same-cycle gnt ROM); 2-cycle bubble per word.
// Backpressure: byte_o held while byte_valid_o && !byte_ready_i; next word is not requested until the current one drains.
// Option: define USER_STR_FETCH_EMIT_NUL_EN to emit the terminating NUL as a final, counted byte.
module user_str_fetch
  import user_str_fetch_pkg::*;
#(
  parameter int unsigned MaxLen = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [ObiAddrWidth-1:0] base_addr_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [StrLenWidth-1:0]  len_o,
  output obi_req_t                obi_req_o,
  input  obi_rsp_t                obi_rsp_i,
  output logic [7:0]              byte_o,
  output logic                    byte_valid_o,
  input  logic                    byte_ready_i
);

`ifdef USER_STR_FETCH_EMIT_NUL_EN
  localparam bit EmitNul = 1'b1;
`else
  localparam bit EmitNul = 1'b0;
`endif

  str_fetch_state_e        state_q, state_d;
  logic [ObiAddrWidth-1:0] addr_q, addr_d;
  logic [31:0]             word_q, word_d;
  logic [1:0]              idx_q, idx_d;
  logic [StrLenWidth-1:0]  cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [StrLenWidth-1:0]  len_q, len_d;

  logic [7:0] cur_byte;
  logic       is_nul;
  logic       last_byte;
  logic       nul_silent;

  // rid, the optional response bit and the sub-word address bits are deliberately ignored.
  logic rsp_unused;
  assign rsp_unused = ^{base_addr_i[1:0], obi_rsp_i.r.rid, obi_rsp_i.r.r_optional};

  assign cur_byte   = str_word_byte(word_q, idx_q);
  assign is_nul     = (cur_byte == StrNul);
  // The byte being handed over now is the MaxLen-th one.
  assign last_byte  = (({1'b0, cnt_q} + 9'd1) == 9'(MaxLen));
  // Without the emit option a NUL ends the string without ever being presented.
  assign nul_silent = is_nul & ~EmitNul;

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);
  assign err_o  = err_q;
  assign len_o  = (state_q == DONE) ? cnt_q : len_q;
  assign byte_o = (state_q == EMIT) ? cur_byte : 8'h00;

  // State and datapath registers, synchronous reset aborts any walk in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      len_q   <= len_d;
    end
  end

  // Next-state, OBI request and byte-stream handshake.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    word_d       = word_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    len_d        = len_q;
    obi_req_o    = '0;
    obi_req_o.a.addr = addr_q;
    obi_req_o.a.be   = 4'hF;
    byte_valid_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = {base_addr_i[ObiAddrWidth-1:2], 2'b00};
          cnt_d   = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          len_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        obi_req_o.req = 1'b1;
        if (obi_rsp_i.gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (obi_rsp_i.rvalid) begin
          if (obi_rsp_i.r.err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            word_d  = obi_rsp_i.r.rdata;
            idx_d   = '0;
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (nul_silent) begin
          state_d = DONE;
        end else begin
          byte_valid_o = 1'b1;
          if (byte_ready_i) begin
            cnt_d = cnt_q + 8'd1;
            if (is_nul || last_byte) begin
              state_d = DONE;
            end else if (idx_q == 2'd3) begin
              addr_d  = addr_q + ObiAddrWidth'(4);
              state_d = REQ;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
      end
      DONE: begin
        len_d   = cnt_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_user_str_fetch.sv
// tb_user_str_fetch: scoreboard bench for user_str_fetch against a behavioural ROM and string-walk model.
// Latency: n/a.
// Backpressure: randomised byte_ready and gnt stalls.
module tb_user_str_fetch;
  import user_str_fetch_pkg::*;

  localparam int MAXLEN = 32;
`ifdef USER_STR_FETCH_EMIT_NUL_EN
  localparam bit EMIT_NUL = 1'b1;
`else
  localparam bit EMIT_NUL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        busy, done, err;
  logic [7:0]  len, byte_dat;
  logic        byte_vld;
  logic        byte_rdy = 1'b1;
  obi_req_t    req;
  obi_rsp_t    rsp;

  always #5 clk = ~clk;

  user_str_fetch #(.MaxLen(MAXLEN)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .len_o        (len),
    .obi_req_o    (req),
    .obi_rsp_i    (rsp),
    .byte_o       (byte_dat),
    .byte_valid_o (byte_vld),
    .byte_ready_i (byte_rdy)
  );

  // ---------------- ROM model ----------------
  logic [7:0]  mem [0:255];
  logic        gnt_en = 1'b1, err_mode = 1'b0, force_rv = 1'b0;
  logic        rv_q = 1'b0, rerr_q = 1'b0;
  logic [31:0] rdata_q = '0;
  logic [31:0] reads [$];
  bit          rdy_rand = 1'b0, gnt_rand = 1'b0;

  always_comb begin
    rsp          = '0;
    rsp.gnt      = req.req & gnt_en;
    rsp.rvalid   = rv_q | force_rv;
    rsp.r.rdata  = force_rv ? 32'h4141_4141 : rdata_q;
    rsp.r.err    = rerr_q & ~force_rv;
  end

  always @(posedge clk) begin
    logic [7:0] ab;
    ab = req.a.addr[7:0];
    rv_q <= req.req & gnt_en;
    if (req.req && gnt_en) begin
      rdata_q <= {mem[ab+8'd3], mem[ab+8'd2], mem[ab+8'd1], mem[ab]};
      rerr_q  <= err_mode;
      reads.push_back(req.a.addr);
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    byte_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    gnt_en   = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_bytes [$];
  int          exp_done  [$];
  logic [31:0] exp_reads [$];
  int          checks = 0, failures = 0, done_count = 0, bytes_seen = 0;
  bit          mon_on = 1'b0, hold_pend = 1'b0, stall_pend = 1'b0;
  logic [7:0]  hold_byte = '0;
  logic [31:0] stall_addr = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h want=0x%0h", nm, act, exp);
    end
  endtask

  // Walk the ROM the way the string rules describe: read a word whenever a new
  // word is entered, stop at NUL or after MAXLEN bytes.
  function automatic void model(input logic [31:0] base, input bit em);
    int a, cnt;
    logic [7:0] b;
    a   = int'(base & 32'hFFFF_FFFC);
    cnt = 0;
    exp_reads.delete();
    exp_reads.push_back(32'(a));
    if (em) begin
      exp_done.push_back(256);
      return;
    end
    for (int i = 0; i < 1024; i++) begin
      if (i > 0 && i % 4 == 0) exp_reads.push_back(32'(a + i));
      b = mem[(a + i) % 256];
      if (b == 8'h00 && !EMIT_NUL) break;
      exp_bytes.push_back(b);
      cnt++;
      if (b == 8'h00 || cnt == MAXLEN) break;
    end
    exp_done.push_back(cnt);
  endfunction

  // Monitor: compares every presented byte/done against the expected queues.
  always @(negedge clk) begin
    int e;
    if (mon_on) begin
      if (hold_pend) begin
        check("valid_held", byte_vld, 1);
        check("byte_stable", byte_dat, hold_byte);
      end
      if (stall_pend) begin
        check("req_held", req.req, 1);
        check("addr_held", req.a.addr, stall_addr);
      end
      if (byte_vld) begin
        check("no_req_in_emit", req.req, 0);
        if (byte_rdy) begin
          bytes_seen++;
          if (exp_bytes.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL byte_extra: got=0x%0h want=none", byte_dat);
          end else begin
            check("byte_seq", byte_dat, exp_bytes.pop_front());
          end
        end
      end
      hold_pend  = byte_vld & ~byte_rdy;
      hold_byte  = byte_dat;
      stall_pend = req.req & ~rsp.gnt;
      stall_addr = req.a.addr;
      if (done) begin
        done_count++;
        check("busy_at_done", busy, 1);
        if (exp_done.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_extra: got=len %0d want=none", len);
        end else begin
          e = exp_done.pop_front();
          check("len_at_done", len, e & 255);
          check("err_at_done", err, e >> 8);
        end
      end
    end else begin
      hold_pend  = 1'b0;
      stall_pend = 1'b0;
    end
  end

  task automatic load_str(input int a, input string s);
    for (int i = 0; i < s.len(); i++) mem[a + i] = s[i];
    mem[a + s.len()] = 8'h00;
  endtask

  task automatic run(input logic [31:0] base, input bit rr, input bit gr, input bit em,
                     input bit rep, input bit lat);
    int target;
    model(base, em);
    rdy_rand = rr;
    gnt_rand = gr;
    err_mode = em;
    reads.delete();
    target = done_count + 1;
    @(negedge clk);
    base_addr = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (lat) begin
      check("lat_req_c1", req.req, 1);
      @(negedge clk);
      check("lat_nobyte_c2", byte_vld, 0);
      @(negedge clk);
      check("lat_byte_c3", byte_vld, 1);
    end
    if (rep) begin
      base_addr = 32'h80;
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 3000 && done_count < target; i++) @(negedge clk);
    if (done_count < target) check("done_timeout", done_count, target);
    repeat (4) @(negedge clk);
    check("done_once", done_count, target);
    check("bytes_left", exp_bytes.size(), 0);
    check("done_left", exp_done.size(), 0);
    check("read_count", reads.size(), exp_reads.size());
    for (int i = 0; i < exp_reads.size() && i < reads.size(); i++)
      check("read_addr", reads[i], exp_reads[i]);
    exp_bytes.delete();
    exp_done.delete();
    rdy_rand = 1'b0;
    gnt_rand = 1'b0;
    err_mode = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=no finish want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req", req.req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_vld", byte_vld, 0);
    check("rst_len", len, 0);
    check("rst_byte", byte_dat, 0);
    rst = 1'b0;
    mon_on = 1'b1;

    // Reference string, no backpressure, latency checked.
    load_str(0, "LN&LK's ASIC");
    bytes_seen = 0;
    run(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s1_bytes", bytes_seen, EMIT_NUL ? 13 : 12);
    check("s1_reads", reads.size(), 4);
    check("s1_len_hold", len, EMIT_NUL ? 13 : 12);

    // Same string with random backpressure and gnt stalls.
    bytes_seen = 0;
    run(32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("s2_bytes", bytes_seen, EMIT_NUL ? 13 : 12);

    // 48 x 'A', no NUL in reach: truncation at MAXLEN.
    for (int i = 0; i < 48; i++) mem[i] = 8'h41;
    bytes_seen = 0;
    run(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s3_bytes", bytes_seen, 32);
    check("s3_reads", reads.size(), 8);
    check("s3_len_hold", len, 32);
    check("s3_err", err, 0);

    // Error response on the first read.
    bytes_seen = 0;
    run(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("s4_bytes", bytes_seen, 0);
    check("s4_err_hold", err, 1);
    check("s4_len_hold", len, 0);

    // Unaligned base and repeated starts while busy.
    for (int i = 128; i < 192; i++) mem[i] = 8'h5A;
    load_str(4, "Hi");
    run(32'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("s5_first_read", (reads.size() > 0) ? reads[0] : 32'hDEAD, 32'h4);
    check("s5_len_hold", len, EMIT_NUL ? 3 : 2);

    // Reset in the middle of EMIT, then a stale rvalid.
    load_str(32, "ABCDEFGHIJ");
    model(32'd32, 1'b0);
    @(negedge clk);
    base_addr = 32'd32;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && !byte_vld; i++) @(negedge clk);
    check("s6_emitting", byte_vld, 1);
    @(negedge clk);
    mon_on = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("s6_rst_req", req.req, 0);
    check("s6_rst_vld", byte_vld, 0);
    check("s6_rst_busy", busy, 0);
    check("s6_rst_done", done, 0);
    check("s6_rst_err", err, 0);
    check("s6_rst_len", len, 0);
    check("s6_rst_byte", byte_dat, 0);
    rst = 1'b0;
    exp_bytes.delete();
    exp_done.delete();
    @(negedge clk);
    force_rv = 1'b1;
    @(negedge clk);
    force_rv = 1'b0;
    mon_on = 1'b1;
    repeat (6) begin
      check("late_rv_vld", byte_vld, 0);
      check("late_rv_busy", busy, 0);
      @(negedge clk);
    end

    // Random strings, random base offsets, backpressure, stalls and errors.
    for (int it = 0; it < 20; it++) begin
      int a, n;
      logic [31:0] b;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(1, 255));
      a = $urandom_range(0, 15) * 4;
      n = $urandom_range(0, 40);
      mem[a + n] = 8'h00;
      b = 32'(a + $urandom_range(0, 3));
      run(b, 1'b1, 1'b1, ($urandom_range(0, 7) == 0), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
